// File: rtl/div_unit.sv
// ============================================================================
//  div_unit : iterative restoring divider for RV64M DIV/REM and W-forms
//  Rev 1.0
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            is_signed_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] div_data_o,
    output logic [XLEN-1:0] rem_data_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] ITER_D = 7'd64;
    localparam logic [6:0] ITER_W = 7'd32;

    state_t state, state_nxt;

    logic [6:0]      cnt;
    logic [XLEN-1:0] rem, quo, dvsr;
    logic            qneg, rneg, word;
    logic [4:0]      tag;

    logic            accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, w_src1;
    logic            a_neg, b_neg, div_zero, sgn_ovf, special;
    logic [XLEN-1:0] sp_quo, sp_rem;

    logic [XLEN:0]   shifted, trial;
    logic            fits;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_sgn, r_sgn, q_fin, r_fin;

    assign accept  = start_i && !flush_i && (state != CALC);
    assign busy_o  = (state == CALC);
    assign valid_o = (state == DONE);

    // Operand preparation: W-forms are widened to 64 bits so the special-case
    // detection and the magnitude logic can be shared between both widths.
    always_comb begin
        a_ext = src1_i;
        b_ext = src2_i;
        w_src1 = {{(XLEN-32){src1_i[31]}}, src1_i[31:0]};
        if (is_word_i) begin
            a_ext = {{(XLEN-32){is_signed_i & src1_i[31]}}, src1_i[31:0]};
            b_ext = {{(XLEN-32){is_signed_i & src2_i[31]}}, src2_i[31:0]};
        end
        a_neg = is_signed_i & a_ext[XLEN-1];
        b_neg = is_signed_i & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        min_val = is_word_i ? {{(XLEN-31){1'b1}}, 31'd0}
                            : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        sgn_ovf  = is_signed_i && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || sgn_ovf;

        sp_quo = div_zero ? '1 : a_ext;
        sp_rem = div_zero ? (is_word_i ? w_src1 : src1_i) : '0;
    end

    // One restoring shift-subtract step plus sign/width fix-up of its result
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, dvsr};
        fits    = !trial[XLEN];
        rem_nxt = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], fits};

        q_sgn = qneg ? -quo_nxt : quo_nxt;
        r_sgn = rneg ? -rem_nxt : rem_nxt;
        q_fin = word ? {{(XLEN-32){q_sgn[31]}}, q_sgn[31:0]} : q_sgn;
        r_fin = word ? {{(XLEN-32){r_sgn[31]}}, r_sgn[31:0]} : r_sgn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == 7'd1) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            qneg       <= 1'b0;
            rneg       <= 1'b0;
            word       <= 1'b0;
            tag        <= '0;
            div_data_o <= '0;
            rem_data_o <= '0;
            rd_o       <= '0;
        end else if (accept) begin
            tag <= rd_i;
            if (special) begin
                div_data_o <= sp_quo;
                rem_data_o <= sp_rem;
                rd_o       <= rd_i;
            end else begin
                // W-form dividend is left-aligned so 32 shifts consume it
                rem  <= '0;
                quo  <= is_word_i ? {a_mag[31:0], 32'd0} : a_mag;
                dvsr <= b_mag;
                qneg <= a_neg ^ b_neg;
                rneg <= a_neg;
                word <= is_word_i;
                cnt  <= is_word_i ? ITER_W : ITER_D;
            end
        end else if (state == CALC && !flush_i) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
                div_data_o <= q_fin;
                rem_data_o <= r_fin;
                rd_o       <= tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  tb_div_unit : scoreboard bench for div_unit against an arithmetic model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, is_signed_i, is_word_i, flush_i;
    logic [63:0] src1_i, src2_i;
    logic [4:0]  rd_i;
    logic        busy_o, valid_o;
    logic [63:0] div_data_o, rem_data_o;
    logic [4:0]  rd_o;

    div_unit #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .is_signed_i(is_signed_i),
        .is_word_i  (is_word_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .div_data_o (div_data_o),
        .rem_data_o (rem_data_o),
        .rd_o       (rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [4:0]  rd;
        int          lat;
        int          due;
    } exp_t;

    exp_t        scb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // RISC-V division semantics straight from the ISA rules
    function automatic exp_t model(input bit sgn, input bit word,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] rd);
        exp_t        e;
        bit          sp;
        logic [31:0] q32, r32;
        int          sa, sb;
        int unsigned ua, ub;
        longint      la, lb;
        longint unsigned lua, lub;
        e.rd = rd;
        sp = 1'b0;
        if (word) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            if (ub == 0) begin
                q32 = '1; r32 = a[31:0]; sp = 1'b1;
            end else if (sgn && sa == 32'sh80000000 && sb == -1) begin
                q32 = 32'h80000000; r32 = '0; sp = 1'b1;
            end else if (sgn) begin
                q32 = 32'(sa / sb); r32 = 32'(sa % sb);
            end else begin
                q32 = ua / ub; r32 = ua % ub;
            end
            e.q = {{32{q32[31]}}, q32};
            e.r = {{32{r32[31]}}, r32};
            e.lat = sp ? 1 : 33;
        end else begin
            la = a; lb = b; lua = a; lub = b;
            if (lub == 0) begin
                e.q = '1; e.r = a; sp = 1'b1;
            end else if (sgn && a == 64'h8000000000000000 && lb == -1) begin
                e.q = a; e.r = '0; sp = 1'b1;
            end else if (sgn) begin
                e.q = 64'(la / lb); e.r = 64'(la % lb);
            end else begin
                e.q = lua / lub; e.r = lua % lub;
            end
            e.lat = sp ? 1 : 65;
        end
        e.due = 0;
        return e;
    endfunction

    // Called right after a falling edge; start is sampled on the next rising edge
    task automatic issue(input bit sgn, input bit word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit push);
        exp_t e;
        e = model(sgn, word, a, b, rd);
        e.due = cyc + e.lat;
        if (push) scb.push_back(e);
        start_i = 1'b1; is_signed_i = sgn; is_word_i = word;
        src1_i = a; src2_i = b; rd_i = rd;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_first_cycle", {63'd0, busy_o}, (e.lat > 1) ? 64'd1 : 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL wait_idle: busy still high after %0d cycles, expected low", n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (scb.size() > 0 && cyc > scb[0].due) begin
                checks++; errors++;
                $display("FAIL valid_timeout: no valid by cycle %0d, expected at %0d", cyc, scb[0].due);
                scb.delete(0);
            end
            if (valid_o) begin
                if (scb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: valid=1 with nothing pending, expected 0");
                end else begin
                    e = scb.pop_front();
                    chk("quotient", div_data_o, e.q);
                    chk("remainder", rem_data_o, e.r);
                    chk("rd_tag", {59'd0, rd_o}, {59'd0, e.rd});
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                    last_q = e.q;
                    last_r = e.r;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          sgn, word;
        logic [63:0] a, b;
        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        is_signed_i = 1'b0; is_word_i = 1'b0;
        src1_i = '0; src2_i = '0; rd_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        chk("reset_valid", {63'd0, valid_o}, 64'd0);
        chk("reset_quotient", div_data_o, 64'd0);
        chk("reset_remainder", rem_data_o, 64'd0);
        chk("reset_rd", {59'd0, rd_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 64'd100, 64'd7, 5'd5, 1'b1);                              wait_idle();
        issue(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd6, 1'b1);                 wait_idle();
        issue(1'b0, 1'b0, 64'h1234, 64'd0, 5'd7, 1'b1);                             wait_idle();
        issue(1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd8, 1'b1);  wait_idle();
        issue(1'b1, 1'b1, 64'h80000000, 64'hFFFFFFFF, 5'd9, 1'b1);                  wait_idle();
        issue(1'b0, 1'b1, 64'h00000000FFFFFFFF, 64'd1, 5'd10, 1'b1);                wait_idle();
        issue(1'b0, 1'b1, 64'hABCD0000DEADBEEF, 64'd0, 5'd11, 1'b1);                wait_idle();

        // Abort mid-iteration; a start presented with the flush is dropped
        issue(1'b0, 1'b0, 64'd999999, 64'd13, 5'd12, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1; start_i = 1'b1; src1_i = 64'd50; src2_i = 64'd0; rd_i = 5'd13;
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        chk("flush_busy", {63'd0, busy_o}, 64'd0);
        chk("flush_keeps_quotient", div_data_o, last_q);
        chk("flush_keeps_remainder", rem_data_o, last_r);
        issue(1'b0, 1'b0, 64'd20, 64'd3, 5'd14, 1'b1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            sgn  = 1'($urandom);
            word = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = word ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    sgn = 1'b1;
                    a = word ? {$urandom, 32'h80000000} : 64'h8000000000000000;
                    b = word ? {$urandom, 32'hFFFFFFFF} : '1;
                end
                2: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 20)); end
                3: b = 64'($urandom_range(1, 255));
                default: ;
            endcase
            issue(sgn, word, a, b, 5'($urandom), 1'b1);
            wait_idle();
        end

        // Asynchronous reset in the middle of an iteration
        issue(1'b1, 1'b0, 64'd123456789, 64'd77, 5'd20, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, busy_o}, 64'd0);
        chk("async_reset_quotient", div_data_o, 64'd0);
        chk("async_reset_remainder", rem_data_o, 64'd0);
        chk("async_reset_rd", {59'd0, rd_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
